tdm_demux_1to4: RTL
===================

# tdm_demux_1to4

Time-division 1-to-4 demultiplexer: receives the serial beat stream produced by a 4:1 mux whose select walks slots 0→1→2→3, re-aligns to a slot-0 sync marker, and distributes the beats to four parallel channel outputs. It sits at the receive end of the channel-sharing link, opposite the 4:1 mux transmit side. A complete frame is published atomically with a one-cycle valid strobe.

## Interface
- W, default 1: width of one slot beat (bits per channel).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  W  beat for the current slot; sampled only when en=1.
- en  input  1  beat strobe; one slot per en cycle, idle cycles allowed between beats.
- sync  input  1  marks the din beat as slot 0; meaningful only when en=1.
- Y  output  4*W  channel outputs: Y[W-1:0]=ch0 … Y[4W-1:3W]=ch3, registered, held between frames.
- valid  output  1  one-cycle pulse: Y was updated with a new complete frame.
- slot  output  2  slot index expected on the next en beat (registered).
- locked  output  1  1 when state is LOCKED.
- sync_err  output  1  one-cycle pulse on a framing violation.

## Operation
- States: HUNT, LOCKED. Reset state HUNT.
- Reset values: Y=0, valid=0, slot=0, locked=0, sync_err=0, shadow regs=0.
- HUNT: en&&!sync beats discarded, no error. en&&sync: din→shadow[0], slot←1, →LOCKED.
- LOCKED, en beat with slot=k:
  - k=0, sync=1: din→shadow[0], slot←1.
  - k=0, sync=0: sync_err pulse, beat discarded, slot←0, →HUNT (Y keeps last frame).
  - k∈{1,2}, sync=0: din→shadow[k], slot←k+1.
  - k=3, sync=0: Y←{din, shadow[2], shadow[1], shadow[0]}, valid pulse, slot←0 (wrap).
  - k∈{1,2,3}, sync=1: sync_err pulse, partial frame discarded (no valid, Y unchanged), beat taken as slot 0: din→shadow[0], slot←1, stay LOCKED.
- en=0: no state, slot, or shadow change; valid and sync_err are 0.
- Y changes only on a valid cycle; never exposes a partial frame.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Latency: Y and valid update at the rising edge that samples the slot-3 beat; valid high exactly one cycle after that edge (until next edge) unless the next beat also completes a frame.
- Minimum frame: 4 consecutive en cycles → one valid per 4 cycles; back-to-back frames give valid every 4th cycle, no bubble.
- sync_err asserted in the cycle following the offending edge, one cycle wide; never coincident with valid.
- rst asserted mid-frame: immediate (asynchronous) return to reset values; partial frame lost; first beat after rst deassertion is handled in HUNT.
- locked rises the cycle after the first accepted sync beat and falls the cycle after a missing-sync error.

## Test plan
- Reset: assert rst mid-stream → Y=0, valid=0, slot=0, locked=0 immediately, without waiting for clk.
- Aligned stream, W=1: en=1 continuously, beats 1,0,1,1 with sync on first → Y=4'b1101, single valid pulse, slot returns to 0, locked=1.
- Hunt: three beats without sync, then sync frame A=1,B=0,C=0,D=1 → no valid/sync_err before sync; Y=4'b1001 after the fourth beat of the synced frame.
- Gapped en, W=4: beats 0xA,0xB,0xC,0xD with en=0 idle cycles between each → Y=16'hDCBA, exactly one valid, no change during idle cycles.
- Early sync: sync reasserted at slot 2 → sync_err one cycle, no valid, Y holds previous frame; following 3 beats complete new frame whose ch0 is the early-sync beat.
- Missing sync: after a good frame, slot-0 beat with sync=0 → sync_err, locked=0, Y unchanged; next frame ignored until a sync beat arrives.

Source files
------------

// File: rtl/tdm_demux_1to4_if.sv
// Serial beat link between the 4:1 TDM mux side and the 1:4 demux.
// master drives beats; slave is the demux receiving them.
interface tdm_demux_1to4_if #(
    parameter int W = 1
);
    logic [W-1:0]   din;
    logic           en;
    logic           sync;
    logic [4*W-1:0] Y;
    logic           valid;
    logic [1:0]     slot;
    logic           locked;
    logic           sync_err;

    modport master (
        output din, en, sync,
        input  Y, valid, slot, locked, sync_err
    );

    modport slave (
        input  din, en, sync,
        output Y, valid, slot, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux_1to4.sv
// 1:4 TDM demultiplexer: aligns to the slot-0 sync marker and
// publishes each complete 4-slot frame atomically with a valid pulse.
module tdm_demux_1to4 #(
    parameter int W = 1
) (
    input  logic             clk,
    input  logic             rst,
    tdm_demux_1to4_if.slave  link
);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          slot_q, slot_d;
    logic [2:0][W-1:0]   sh_q, sh_d;
    logic [4*W-1:0]      y_q, y_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            slot_q  <= 2'd0;
            sh_q    <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            sh_q    <= sh_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        sh_d    = sh_q;
        y_d     = y_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (link.en) begin
            unique case (state_q)
                HUNT: begin
                    if (link.sync) begin
                        sh_d[0] = link.din;
                        slot_d  = 2'd1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (slot_q == 2'd0 && !link.sync) begin
                        err_d   = 1'b1;
                        slot_d  = 2'd0;
                        state_d = HUNT;
                    end else if (link.sync) begin
                        // an early sync restarts the frame with this beat as ch0
                        err_d   = (slot_q != 2'd0);
                        sh_d[0] = link.din;
                        slot_d  = 2'd1;
                    end else if (slot_q == 2'd3) begin
                        y_d     = {link.din, sh_q[2], sh_q[1], sh_q[0]};
                        valid_d = 1'b1;
                        slot_d  = 2'd0;
                    end else begin
                        sh_d[slot_q] = link.din;
                        slot_d       = slot_q + 2'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign link.Y        = y_q;
    assign link.valid    = valid_q;
    assign link.slot     = slot_q;
    assign link.locked   = (state_q == LOCKED);
    assign link.sync_err = err_q;

endmodule
